// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ valid/ready requesters.
// Optional per-requester lock (back-to-back bytes from one source) when UART_ARB_LOCK_EN is defined.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WDOG_CLKS = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [7:0]               uart_byte,
  output logic                     uart_start,
  input  logic                     uart_done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     wdog_err
`ifdef UART_ARB_LOCK_EN
  ,
  input  logic [N_REQ-1:0]         req_lock
`endif
);

  localparam int GW = $clog2(N_REQ);
  localparam int WW = (WDOG_CLKS > 0) ? $clog2(WDOG_CLKS + 1) : 1;
  localparam bit WDOG_ON = (WDOG_CLKS > 0);
  localparam logic [WW-1:0] WDOG_LIM = WDOG_ON ? WW'(WDOG_CLKS - 1) : '0;

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  state_t          state_r;
  logic [GW-1:0]   last_r;
  logic [WW-1:0]   wdog_cnt_r;
  logic [GW-1:0]   win_s;
  logic [GW-1:0]   idx_s;
  logic            win_vld_s;
  logic            wdog_hit_s;
`ifdef UART_ARB_LOCK_EN
  logic            locked_r;
`endif

  assign wdog_hit_s = WDOG_ON && (wdog_cnt_r == WDOG_LIM);

  // Winner search: nearest valid requester after last_r, wrapping; a held lock overrides.
  always_comb begin
    win_s     = '0;
    win_vld_s = 1'b0;
    idx_s     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx_s = GW'((int'(last_r) + k) % N_REQ);
      if (req_valid[idx_s]) begin
        win_s     = idx_s;
        win_vld_s = 1'b1;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
`ifdef UART_ARB_LOCK_EN
    if (locked_r && req_valid[last_r]) begin
      win_s     = last_r;
      win_vld_s = 1'b1;
    end else begin
      win_vld_s = win_vld_s;
    end
`endif
  end

  // Ready is a same-cycle grant strobe, only while idle and never during reset.
  always_comb begin
    req_ready = '0;
    if ((state_r == IDLE) && win_vld_s && !rst) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Transmitter sequencing FSM with registered outputs and done watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      last_r     <= GW'(N_REQ - 1);
      wdog_cnt_r <= '0;
      uart_byte  <= 8'h00;
      uart_start <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= '0;
      wdog_err   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      locked_r   <= 1'b0;
`endif
    end else begin
      uart_start <= 1'b0;
      wdog_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (win_vld_s) begin
            uart_byte  <= req_data[int'(win_s)*8 +: 8];
            grant_id   <= win_s;
            last_r     <= win_s;
            uart_start <= 1'b1;
            busy       <= 1'b1;
            state_r    <= START;
`ifdef UART_ARB_LOCK_EN
            locked_r   <= req_lock[win_s];
`endif
          end else begin
            busy       <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            locked_r   <= 1'b0;
`endif
          end
        end
        START: begin
          wdog_cnt_r <= '0;
          state_r    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (wdog_hit_s) begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            wdog_err <= 1'b1;
`ifdef UART_ARB_LOCK_EN
            locked_r <= 1'b0;
`endif
          end else if (uart_done) begin
            wdog_cnt_r <= wdog_cnt_r + 1'b1;
            state_r    <= WAIT_LO;
          end else begin
            wdog_cnt_r <= wdog_cnt_r + 1'b1;
          end
        end
        WAIT_LO: begin
          // Completion wins over a watchdog limit reached in the same cycle.
          if (!uart_done) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (wdog_hit_s) begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            wdog_err <= 1'b1;
`ifdef UART_ARB_LOCK_EN
            locked_r <= 1'b0;
`endif
          end else begin
            wdog_cnt_r <= wdog_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, WDOG_CLKS=50) with a simple TX model.
// The lock scenario is exercised only when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int WDOG    = 50;
  localparam int TX_HI   = 27;
  localparam int TX_LEN  = 30;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_data = {8'hA3, 8'hA2, 8'hA1, 8'h55};
  logic [N-1:0] req_ready;
  logic [7:0]   uart_byte;
  logic         uart_start;
  logic         uart_done;
  logic         busy;
  logic [1:0]   grant_id;
  logic         wdog_err;
  logic [N-1:0] req_lock = '0;
  logic         tx_en = 1'b1;
  int           tx_cnt;

  int           num_checks = 0;
  int           num_errors = 0;
  int           acc_q[$];
  logic [7:0]   start_q[$];

  uart_tx_arbiter #(.N_REQ(N), .WDOG_CLKS(WDOG)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_byte(uart_byte), .uart_start(uart_start),
    .uart_done(uart_done), .busy(busy), .grant_id(grant_id), .wdog_err(wdog_err)
`ifdef UART_ARB_LOCK_EN
    , .req_lock(req_lock)
`endif
  );

  always #5 clk = ~clk;

  // Transmitter model: done high for a few cycles near the end of each byte.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt    <= 0;
      uart_done <= 1'b0;
    end else if (tx_cnt != 0) begin
      tx_cnt    <= (tx_cnt == TX_LEN) ? 0 : tx_cnt + 1;
      uart_done <= (tx_cnt >= TX_HI) && (tx_cnt < TX_LEN);
    end else if (uart_start && tx_en) begin
      tx_cnt <= 1;
    end
  end

  // Record accepted requesters and the byte presented with each start pulse.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) acc_q.push_back(i);
      end
      if (uart_start) start_q.push_back(uart_byte);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_acc(input int n, input string tag);
    int k = 0;
    while (acc_q.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (acc_q.size() < n) chk(tag, acc_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk(tag, busy, 1'b0);
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (!uart_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!uart_start) chk(tag, uart_start, 1'b1);
  endtask

  initial begin
    int base;
    int sbase;
    int k;
    bit seen_hi;
    bit byte_ok;
    bit early_err;
    int exp2[6] = '{0, 1, 2, 3, 0, 1};

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", uart_start, 1'b0);
    chk("rst_byte", uart_byte, 8'h00);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_wdog", wdog_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", req_ready, 4'b0000);

    // 1: single byte from requester 0
    sbase = start_q.size();
    req_valid = 4'b0001;
    #1;
    chk("t1_ready_T", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    chk("t1_start_T1", uart_start, 1'b1);
    chk("t1_byte", uart_byte, 8'h55);
    chk("t1_busy", busy, 1'b1);
    chk("t1_ready_off", req_ready, 4'b0000);
    chk("t1_grant", grant_id, 2'd0);
    @(negedge clk);
    chk("t1_start_once", uart_start, 1'b0);
    seen_hi = 1'b0;
    byte_ok = 1'b1;
    k = 0;
    while (k < 200 && !(seen_hi && !uart_done)) begin
      if (uart_done) seen_hi = 1'b1;
      if (uart_byte != 8'h55 || !busy) byte_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("t1_done_seen", seen_hi, 1'b1);
    chk("t1_byte_held", byte_ok, 1'b1);
    chk("t1_busy_at_fall", busy, 1'b1);
    @(negedge clk);
    chk("t1_busy_after", busy, 1'b0);
    chk("t1_one_start", start_q.size() - sbase, 1);

    // 2: fresh reset, all four valid -> 0,1,2,3,0,1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = acc_q.size();
    sbase = start_q.size();
    req_valid = 4'b1111;
    wait_acc(base + 6, "t2_timeout");
    req_valid = 4'b0000;
    wait_idle("t2_idle_timeout");
    for (int i = 0; i < 6; i++) begin
      if (acc_q.size() > base + i) chk($sformatf("t2_order%0d", i), acc_q[base + i], exp2[i]);
    end
    chk("t2_starts", start_q.size() - sbase, 6);

    // 3: last=1, valid=1010 -> 3 then 1
    base = acc_q.size();
    req_valid = 4'b1010;
    wait_acc(base + 1, "t3a_timeout");
    if (acc_q.size() > base) chk("t3_first", acc_q[base], 3);
    chk("t3_grant3", grant_id, 2'd3);
    wait_acc(base + 2, "t3b_timeout");
    req_valid = 4'b0000;
    if (acc_q.size() > base + 1) chk("t3_second", acc_q[base + 1], 1);
    chk("t3_grant1", grant_id, 2'd1);
    wait_idle("t3_idle_timeout");

    // 4: watchdog with done stuck low
    tx_en = 1'b0;
    base = acc_q.size();
    req_valid = 4'b0100;
    wait_start("t4_start_timeout");
    req_valid = 4'b0000;
    early_err = 1'b0;
    for (int i = 1; i <= WDOG; i++) begin
      @(negedge clk);
      if (wdog_err) early_err = 1'b1;
    end
    chk("t4_no_early_err", early_err, 1'b0);
    chk("t4_busy_before", busy, 1'b1);
    @(negedge clk);
    chk("t4_wdog_pulse", wdog_err, 1'b1);
    chk("t4_busy_abort", busy, 1'b0);
    tx_en = 1'b1;
    @(negedge clk);
    chk("t4_wdog_single", wdog_err, 1'b0);
    if (acc_q.size() > base) chk("t4_aborted_id", acc_q[base], 2);
    req_valid = 4'b1100;
    wait_acc(base + 2, "t4_next_timeout");
    req_valid = 4'b0000;
    if (acc_q.size() > base + 1) chk("t4_next", acc_q[base + 1], 3);
    wait_idle("t4_idle_timeout");

    // 5: reset during WAIT_HI, then 1111 grants from 0
    req_valid = 4'b0001;
    wait_start("t5_start_timeout");
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_start", uart_start, 1'b0);
    chk("t5_byte", uart_byte, 8'h00);
    chk("t5_grant", grant_id, 2'd0);
    chk("t5_wdog", wdog_err, 1'b0);
    chk("t5_ready", req_ready, 4'b0000);
    @(negedge clk);
    base = acc_q.size();
    rst = 1'b0;
    wait_acc(base + 4, "t5_timeout");
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (acc_q.size() > base + i) chk($sformatf("t5_order%0d", i), acc_q[base + i], i);
    end
    wait_idle("t5_idle_timeout");

`ifdef UART_ARB_LOCK_EN
    // 6: requester 0 locks for three bytes while requester 1 waits
    base = acc_q.size();
    req_lock = 4'b0001;
    req_valid = 4'b0011;
    wait_acc(base + 2, "t6a_timeout");
    req_lock = 4'b0000;
    wait_acc(base + 3, "t6b_timeout");
    req_valid = 4'b0010;
    wait_acc(base + 4, "t6c_timeout");
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (acc_q.size() > base + i) chk($sformatf("t6_order%0d", i), acc_q[base + i], (i < 3) ? 0 : 1);
    end
    wait_idle("t6_idle_timeout");
`endif

    // Every start presented the byte of the requester accepted for it
    chk("bytes_count", start_q.size(), acc_q.size());
    for (int i = 0; i < acc_q.size() && i < start_q.size(); i++) begin
      chk($sformatf("byte%0d", i), start_q[i], req_data[acc_q[i]*8 +: 8]);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
